voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice scheduler between the MIDI/DSP event path and the bank of `oscillator` instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of `NUM_VOICES` oscillator slots. When no slot is free it steals the oldest voice. It drives each oscillator's note, velocity, wave select and enable, and emits a one-cycle retrigger pulse so the oscillator restarts its phase.

## Interface
- `NUM_VOICES`, 4: number of oscillator slots; range 2–8.
- `AGE_W`, 8: width of the per-voice saturating age counter.
- `clk`  in  1: system clock, 50 MHz.
- `reset`  in  1: asynchronous, active-high reset.
- `ev_valid`  in  1: event present.
- `ev_ready`  out  1: block can accept an event.
- `ev_on`  in  1: 1 = note-on, 0 = note-off.
- `ev_note`  in  7: MIDI note number.
- `ev_velocity`  in  7: MIDI velocity.
- `ev_wave_sel`  in  2: waveform select, latched with a note-on.
- `panic`  in  1: all-notes-off request, level-sampled.
- `voice_note`  out  7×NUM_VOICES: per-slot note.
- `voice_velocity`  out  7×NUM_VOICES: per-slot velocity.
- `voice_wave_sel`  out  2×NUM_VOICES: per-slot waveform.
- `voice_en`  out  NUM_VOICES: per-slot note enable.
- `voice_retrig`  out  NUM_VOICES: one-cycle phase-restart pulse.

## Operation
- The block has three states:
  - IDLE: `ev_ready`=1. On `ev_valid & ev_ready`, latch `ev_*` and go to SCAN with `idx`=0.
  - SCAN: examines slot `idx`, one slot per cycle, for `NUM_VOICES` cycles. It tracks the following:
    - Match: lowest index with `voice_en` set and `voice_note`==latched note.
    - Free: lowest index with `voice_en`=0.
    - Oldest: largest age among enabled slots; ties go to the lowest index.
    - After `idx`==NUM_VOICES-1, go to COMMIT.
  - COMMIT: applies the event in one cycle, then returns to IDLE.
- A note-on with velocity 0 is treated as a note-off.
- Note-on target priority:
  1. Match. Update velocity and wave_sel, pulse retrig.
  2. Free slot.
  3. Oldest slot (steal).
- For the note-on target slot:
  - Write note, velocity and wave_sel; set `voice_en`=1; pulse `voice_retrig`; set age to 0.
  - Every other enabled slot's age increments, saturating at 2^AGE_W−1.
  - Disabled slots keep their age frozen.
- Note-off:
  - If there is a match, clear that slot's `voice_en`. Note, velocity and wave_sel keep their last values, and no retrig is issued.
  - If there is no match, the event is consumed with no output change.
- Panic takes precedence over everything:
  - In any state, `panic`=1 clears all `voice_en`, all ages and all retrig, and forces IDLE.
  - An event in flight is discarded.
  - `ev_ready`=0 while `panic`=1.
- Duplicate enabled notes never arise: a note-on always resolves to the existing match first.

## Timing
- Reset values:
  - State IDLE, `ev_ready`=1.
  - All `voice_en`, `voice_retrig`, `voice_note`, `voice_velocity`, `voice_wave_sel` and ages are 0.
- `ev_ready` is combinational: (state==IDLE) & ~panic. `ev_*` are sampled only on the accept edge.
- Latency: if acceptance happens at edge E0, SCAN covers edges E1..E_N, and COMMIT registers its outputs at edge E_{N+1}.
  - Outputs change and `voice_retrig` goes high for exactly one cycle after E_{N+1}.
  - `ev_ready` returns to 1 at E_{N+1}.
  - Throughput is one event per NUM_VOICES+2 cycles (6 cycles at the default).
- `voice_retrig` is never high for two consecutive cycles.
- Panic asserted during COMMIT wins: no slot is written.
- Reset asserted mid-SCAN restores all reset values immediately, asynchronously.
- Outputs are fully registered; there is no combinational path from `ev_*` to `voice_*`.

## Test plan
- **Fill:** reset, then note-on 60/v100, 62/v90, 64/v80, 67/v70 → slots 0–3 enabled with those notes. Each `voice_retrig` bit pulses once, 6 cycles after its accept. Ages after the last event are 3,2,1,0.
- **Steal:** after Fill, note-on 72/v50 → slot 0 becomes note 72 and is retriggered. Ages become 0,3,2,1. Slots 1–3 are unchanged.
- **Retrigger same note:** note-on 62/v127 while 62 sits in slot 1 → slot 1 velocity=127, retrig pulse, age 0. No other slot changes note.
- **Note-off:** note-off 64 → slot 2 `voice_en`=0 and note stays 64. Then note-on 65 → lands in slot 2 (free beats oldest).
- **Velocity-zero / unmatched off:** note-on 67/v0 → slot 3 disabled. Then note-off 10 with no match → no output change, and `ev_ready` back after 6 cycles.
- **Panic mid-event:** accept note-on 70, assert `panic` during SCAN cycle 2 → all `voice_en`=0 next edge. Slot contents for 70 are never written. `ev_ready`=0 while `panic` is high, then 1 after release.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the oscillator slots one per cycle, then assigns a note-on to
// the matching, free or oldest slot, or releases the matching slot on note-off.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_velocity,
  input  logic [1:0]              ev_wave_sel,
  input  logic                    panic,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic [2*NUM_VOICES-1:0] voice_wave_sel,
  output logic [NUM_VOICES-1:0]   voice_en,
  output logic [NUM_VOICES-1:0]   voice_retrig
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            on_q, on_d;
  logic [6:0]      note_q, note_d, vel_q, vel_d;
  logic [1:0]      wave_q, wave_d;

  logic            match_vld_q, match_vld_d, free_vld_q, free_vld_d, old_vld_q, old_vld_d;
  logic [IdxW-1:0] match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;

  logic [NUM_VOICES-1:0] en_q, en_d, retrig_q, retrig_d;
  logic [6:0]       slot_note_q [NUM_VOICES];
  logic [6:0]       slot_note_d [NUM_VOICES];
  logic [6:0]       slot_vel_q  [NUM_VOICES];
  logic [6:0]       slot_vel_d  [NUM_VOICES];
  logic [1:0]       slot_wave_q [NUM_VOICES];
  logic [1:0]       slot_wave_d [NUM_VOICES];
  logic [AGE_W-1:0] age_q       [NUM_VOICES];
  logic [AGE_W-1:0] age_d       [NUM_VOICES];

  logic [IdxW-1:0] tgt;

  assign ev_ready = (state_q == StIdle) & ~panic;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    vel_d       = vel_q;
    wave_d      = wave_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    en_d        = en_q;
    retrig_d    = '0;
    slot_note_d = slot_note_q;
    slot_vel_d  = slot_vel_q;
    slot_wave_d = slot_wave_q;
    age_d       = age_q;
    tgt         = old_idx_q;

    if (panic) begin
      state_d = StIdle;
      en_d    = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) age_d[i] = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ev_valid) begin
            // Velocity-zero note-on is folded into a note-off here.
            on_d        = ev_on & (ev_velocity != 7'd0);
            note_d      = ev_note;
            vel_d       = ev_velocity;
            wave_d      = ev_wave_sel;
            match_vld_d = 1'b0;
            free_vld_d  = 1'b0;
            old_vld_d   = 1'b0;
            idx_d       = '0;
            state_d     = StScan;
          end
        end
        StScan: begin
          if (en_q[idx_q]) begin
            if (!match_vld_q && slot_note_q[idx_q] == note_q) begin
              match_vld_d = 1'b1;
              match_idx_d = idx_q;
            end
            // Strict compare keeps the lowest index on age ties.
            if (!old_vld_q || age_q[idx_q] > old_age_q) begin
              old_vld_d = 1'b1;
              old_idx_d = idx_q;
              old_age_d = age_q[idx_q];
            end
          end else if (!free_vld_q) begin
            free_vld_d = 1'b1;
            free_idx_d = idx_q;
          end
          if (idx_q == IdxW'(NUM_VOICES - 1)) state_d = StCommit;
          else idx_d = idx_q + 1'b1;
        end
        StCommit: begin
          state_d = StIdle;
          if (match_vld_q)     tgt = match_idx_q;
          else if (free_vld_q) tgt = free_idx_q;
          if (on_q) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (IdxW'(i) == tgt) begin
                slot_note_d[i] = note_q;
                slot_vel_d[i]  = vel_q;
                slot_wave_d[i] = wave_q;
                en_d[i]        = 1'b1;
                retrig_d[i]    = 1'b1;
                age_d[i]       = '0;
              end else if (en_q[i] && age_q[i] != '1) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
          end else if (match_vld_q) begin
            en_d[match_idx_q] = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      vel_q       <= '0;
      wave_q      <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      en_q        <= '0;
      retrig_q    <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        slot_note_q[i] <= '0;
        slot_vel_q[i]  <= '0;
        slot_wave_q[i] <= '0;
        age_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      wave_q      <= wave_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      en_q        <= en_d;
      retrig_q    <= retrig_d;
      slot_note_q <= slot_note_d;
      slot_vel_q  <= slot_vel_d;
      slot_wave_q <= slot_wave_d;
      age_q       <= age_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_note[7*g +: 7]     = slot_note_q[g];
    assign voice_velocity[7*g +: 7] = slot_vel_q[g];
    assign voice_wave_sel[2*g +: 2] = slot_wave_q[g];
  end
  assign voice_en     = en_q;
  assign voice_retrig = retrig_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, panic/reset corner sequences and random
// events checked against a slot-search reference model.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ev_valid, ev_on, panic;
  logic          ev_ready;
  logic [6:0]    ev_note, ev_velocity;
  logic [1:0]    ev_wave_sel;
  logic [7*NV-1:0] voice_note, voice_velocity;
  logic [2*NV-1:0] voice_wave_sel;
  logic [NV-1:0] voice_en, voice_retrig;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_velocity(ev_velocity), .ev_wave_sel(ev_wave_sel), .panic(panic),
    .voice_note(voice_note), .voice_velocity(voice_velocity), .voice_wave_sel(voice_wave_sel),
    .voice_en(voice_en), .voice_retrig(voice_retrig)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit       m_en   [NV];
  bit [6:0] m_note [NV];
  bit [6:0] m_vel  [NV];
  bit [1:0] m_wave [NV];
  int       m_age  [NV];

  // Snapshot taken one cycle after commit
  logic [NV-1:0]   s_en, s_rt;
  logic [7*NV-1:0] s_note;

  typedef struct {
    bit       on;
    bit [6:0] note;
    bit [6:0] vel;
    bit [1:0] wave;
    bit [3:0] en;
    bit [3:0] rt;
    bit [27:0] notes;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_en[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_wave[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_panic();
    for (int i = 0; i < NV; i++) begin
      m_en[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_event(input bit on, input bit [6:0] note, input bit [6:0] vel,
                             input bit [1:0] wave, output logic [NV-1:0] rt);
    int match = -1, free = -1, old = -1, tgt;
    for (int i = 0; i < NV; i++) begin
      if (m_en[i]) begin
        if (match < 0 && m_note[i] == note) match = i;
        if (old < 0 || m_age[i] > m_age[old]) old = i;
      end else if (free < 0) free = i;
    end
    rt = '0;
    if (on && vel != 0) begin
      tgt = (match >= 0) ? match : (free >= 0) ? free : old;
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_en[i] && m_age[i] < 255) m_age[i]++;
      m_en[tgt] = 1; m_note[tgt] = note; m_vel[tgt] = vel; m_wave[tgt] = wave;
      m_age[tgt] = 0;
      rt[tgt] = 1'b1;
    end else if (match >= 0) begin
      m_en[match] = 0;
    end
  endtask

  function automatic logic [7*NV-1:0] exp_note();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = m_note[i];
    return r;
  endfunction

  function automatic logic [7*NV-1:0] exp_vel();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = m_vel[i];
    return r;
  endfunction

  function automatic logic [2*NV-1:0] exp_wave();
    logic [2*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[2*i +: 2] = m_wave[i];
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_en();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_en[i];
    return r;
  endfunction

  // Called and returning at posedge+1; full accept-to-commit transaction with timing checks.
  task automatic do_event(input bit on, input bit [6:0] note, input bit [6:0] vel,
                          input bit [1:0] wave);
    int t = 0;
    bit busy_ok = 1;
    logic [NV-1:0] rt;
    while (!ev_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("ready_wait", ev_ready, 1'b1);
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_velocity = vel; ev_wave_sel = wave;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    ev_on = 1'($urandom); ev_note = 7'($urandom); ev_velocity = 7'($urandom);
    ev_wave_sel = 2'($urandom);
    model_event(on, note, vel, wave, rt);
    for (int k = 1; k <= NV; k++) begin
      @(posedge clk); #1;
      if (ev_ready !== 1'b0 || voice_retrig !== '0) busy_ok = 0;
    end
    check("busy_window", busy_ok, 1'b1);
    @(posedge clk); #1;
    s_en = voice_en; s_rt = voice_retrig; s_note = voice_note;
    check("retrig", voice_retrig, rt);
    check("en", voice_en, exp_en());
    check("note", voice_note, exp_note());
    check("velocity", voice_velocity, exp_vel());
    check("wave_sel", voice_wave_sel, exp_wave());
    check("ready_back", ev_ready, 1'b1);
    @(posedge clk); #1;
    check("retrig_single", voice_retrig, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 7'd60, 7'd100, 2'd1, 4'b0001, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd60}};
    tbl[1]  = '{1'b1, 7'd62, 7'd90,  2'd2, 4'b0011, 4'b0010, {7'd0, 7'd0, 7'd62, 7'd60}};
    tbl[2]  = '{1'b1, 7'd64, 7'd80,  2'd3, 4'b0111, 4'b0100, {7'd0, 7'd64, 7'd62, 7'd60}};
    tbl[3]  = '{1'b1, 7'd67, 7'd70,  2'd0, 4'b1111, 4'b1000, {7'd67, 7'd64, 7'd62, 7'd60}};
    tbl[4]  = '{1'b1, 7'd72, 7'd50,  2'd1, 4'b1111, 4'b0001, {7'd67, 7'd64, 7'd62, 7'd72}};
    tbl[5]  = '{1'b1, 7'd62, 7'd127, 2'd2, 4'b1111, 4'b0010, {7'd67, 7'd64, 7'd62, 7'd72}};
    tbl[6]  = '{1'b0, 7'd64, 7'd0,   2'd0, 4'b1011, 4'b0000, {7'd67, 7'd64, 7'd62, 7'd72}};
    tbl[7]  = '{1'b1, 7'd65, 7'd60,  2'd3, 4'b1111, 4'b0100, {7'd67, 7'd65, 7'd62, 7'd72}};
    tbl[8]  = '{1'b1, 7'd67, 7'd0,   2'd1, 4'b0111, 4'b0000, {7'd67, 7'd65, 7'd62, 7'd72}};
    tbl[9]  = '{1'b0, 7'd10, 7'd33,  2'd2, 4'b0111, 4'b0000, {7'd67, 7'd65, 7'd62, 7'd72}};
    tbl[10] = '{1'b1, 7'd80, 7'd10,  2'd0, 4'b1111, 4'b1000, {7'd80, 7'd65, 7'd62, 7'd72}};
    // Ages are now 3,2,1,0 so slot 0 is the steal victim.
    tbl[11] = '{1'b1, 7'd81, 7'd10,  2'd1, 4'b1111, 4'b0001, {7'd80, 7'd65, 7'd62, 7'd81}};

    reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_velocity = '0;
    ev_wave_sel = '0; panic = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", voice_en, '0);
    check("rst_retrig", voice_retrig, '0);
    check("rst_note", voice_note, '0);
    check("rst_vel", voice_velocity, '0);
    check("rst_wave", voice_wave_sel, '0);
    check("rst_ready", ev_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_event(tbl[i].on, tbl[i].note, tbl[i].vel, tbl[i].wave);
      check($sformatf("tbl%0d_en", i), s_en, tbl[i].en);
      check($sformatf("tbl%0d_retrig", i), s_rt, tbl[i].rt);
      check($sformatf("tbl%0d_note", i), s_note, tbl[i].notes);
    end

    // Panic during SCAN: event for note 70 must be discarded.
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_velocity = 7'd90; ev_wave_sel = 2'd1;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #1;
    panic = 1'b1;
    #1;
    check("panic_ready_low", ev_ready, 1'b0);
    model_panic();
    @(posedge clk); #1;
    check("panic_en", voice_en, '0);
    check("panic_retrig", voice_retrig, '0);
    check("panic_note", voice_note, exp_note());
    @(posedge clk); #1;
    check("panic_ready_held", ev_ready, 1'b0);
    panic = 1'b0;
    #1;
    check("panic_ready_release", ev_ready, 1'b1);
    repeat (NV + 2) @(posedge clk);
    #1;
    check("panic_discard_en", voice_en, '0);
    check("panic_discard_note", voice_note, exp_note());

    // Panic landing on the COMMIT edge wins.
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd71; ev_velocity = 7'd20; ev_wave_sel = 2'd3;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    repeat (NV) @(posedge clk);
    #1;
    panic = 1'b1;
    @(posedge clk); #1;
    check("commit_panic_en", voice_en, '0);
    check("commit_panic_retrig", voice_retrig, '0);
    check("commit_panic_note", voice_note, exp_note());
    panic = 1'b0;
    @(posedge clk); #1;

    do_event(1'b1, 7'd50, 7'd40, 2'd2);

    // Asynchronous reset mid-SCAN.
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd55; ev_velocity = 7'd44; ev_wave_sel = 2'd1;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_en", voice_en, '0);
    check("async_rst_note", voice_note, '0);
    check("async_rst_ready", ev_ready, 1'b1);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        panic = 1'b1;
        @(posedge clk); #1;
        panic = 1'b0;
        model_panic();
        check("rand_panic_en", voice_en, '0);
      end
      do_event($urandom_range(0, 3) != 0, 7'(40 + $urandom_range(0, 7)),
               ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
               2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
